instruction_loader: RTL and testbench

Boot-time writer for the CPU's word-addressed instruction memory. It accepts a byte stream (from a UART receiver or testbench) framed as a 16-bit word-count header followed by instruction bytes. It assembles big-endian 32-bit words and issues one single-cycle write per word into the instruction memory's write port. While loading, it holds the CPU core off so that no fetch sees a partially written program.

---
 rtl/instruction_loader_pkg.sv | 18 +
 rtl/instruction_loader_byte_assembler.sv | 38 +++
 rtl/instruction_loader.sv | 165 ++++++++++++++++
 tb/tb_instruction_loader.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the boot-time instruction loader: FSM states and
// framing constants for the header and big-endian word assembly.
package instruction_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_DATA  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;

  localparam int BYTE_CNT_W = $clog2(BYTES_PER_WORD);
  localparam int HDR_IDX_W  = $clog2(HDR_BYTES);

endpackage

// File: rtl/instruction_loader_byte_assembler.sv
// Shifts stream bytes into a 32-bit big-endian word and flags the byte that
// completes the word, so the caller can react in the same cycle.
module byte_assembler
  import instruction_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_i,
  input  logic        shift_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_complete_o
);

  logic [31:0]           shift_q;
  logic [BYTE_CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (shift_en_i) begin
      shift_q <= {shift_q[23:0], byte_i};
      cnt_q   <= cnt_q + BYTE_CNT_W'(1);
    end
  end

  // After the completing byte is shifted in, shift_q holds the full word
  // until the next shift, which cannot happen while the word is written.
  assign word_o          = shift_q;
  assign word_complete_o = shift_en_i && (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instruction_loader.sv
// Boot loader: parses a 16-bit word-count header, then writes assembled
// big-endian words into instruction memory while holding the CPU off.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                Start,
  input  logic                ByteValid,
  input  logic [7:0]          ByteData,
  output logic                ByteReady,
  output logic                WriteEnable,
  output logic [31:0]         WriteAddress,
  output logic [31:0]         WriteData,
  output logic                Busy,
  output logic                CpuHold,
  output logic                Done,
  output logic                Error,
  output logic [ADDR_WIDTH:0] WordsWritten
);

  localparam int CNT_W = ADDR_WIDTH + 1;

  state_e                state_q, state_d;
  logic [HDR_IDX_W-1:0]  hdr_idx_q, hdr_idx_d;
  logic [7:0]            hdr_hi_q, hdr_hi_d;
  logic [15:0]           n_q, n_d;
  logic [CNT_W-1:0]      words_q, words_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [31:0]           waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;

  logic                  xfer;
  logic                  asm_clear;
  logic                  asm_shift;
  logic                  word_complete;
  logic [31:0]           asm_word;
  logic [15:0]           hdr_n;
  logic [CNT_W-1:0]      words_inc;

  assign ByteReady = (state_q == ST_HDR) || (state_q == ST_DATA);
  assign xfer      = ByteValid && ByteReady;
  assign asm_clear = (state_q == ST_IDLE) && Start;
  assign asm_shift = xfer && (state_q == ST_DATA);
  assign hdr_n     = {hdr_hi_q, ByteData};
  assign words_inc = words_q + CNT_W'(1);

  byte_assembler u_byte_assembler (
    .clk             (clk),
    .reset_n         (reset_n),
    .clear_i         (asm_clear),
    .shift_en_i      (asm_shift),
    .byte_i          (ByteData),
    .word_o          (asm_word),
    .word_complete_o (word_complete)
  );

  // NOTE: every _d gets its default first, so no branch can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    hdr_idx_d = hdr_idx_q;
    hdr_hi_d  = hdr_hi_q;
    n_d       = n_q;
    words_d   = words_q;
    done_d    = done_q;
    error_d   = error_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d   = ST_HDR;
          hdr_idx_d = '0;
          words_d   = '0;
          done_d    = 1'b0;
          error_d   = 1'b0;
        end
      end

      ST_HDR: begin
        if (xfer) begin
          if (hdr_idx_q != HDR_IDX_W'(HDR_BYTES - 1)) begin
            hdr_hi_d  = ByteData;
            hdr_idx_d = hdr_idx_q + HDR_IDX_W'(1);
          end else begin
            n_d       = hdr_n;
            hdr_idx_d = '0;
            if (hdr_n == '0) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else if (hdr_n > 16'(DEPTH)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              error_d = 1'b1;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
      end

      ST_DATA: begin
        if (word_complete) begin
          state_d = ST_WRITE;
          waddr_d = 32'(words_q);
        end
      end

      ST_WRITE: begin
        words_d = words_inc;
        wdata_d = asm_word;
        if (16'(words_inc) == n_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DATA;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      hdr_idx_q <= '0;
      hdr_hi_q  <= '0;
      n_q       <= '0;
      words_q   <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      hdr_idx_q <= hdr_idx_d;
      hdr_hi_q  <= hdr_hi_d;
      n_q       <= n_d;
      words_q   <= words_d;
      done_q    <= done_d;
      error_q   <= error_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  // During WRITE the assembler already holds the word; wdata_q keeps it
  // visible afterwards while the next word is being shifted in.
  assign WriteEnable  = (state_q == ST_WRITE);
  assign WriteAddress = waddr_q;
  assign WriteData    = (state_q == ST_WRITE) ? asm_word : wdata_q;
  assign Busy         = (state_q != ST_IDLE);
  assign CpuHold      = Busy;
  assign Done         = done_q;
  assign Error        = error_q;
  assign WordsWritten = words_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: expected writes are queued as the
// stream is driven and popped by a monitor whenever WriteEnable is seen.
`timescale 1ns/1ps
module tb_instruction_loader;

  localparam int ADDR_WIDTH = 6;
  localparam int DEPTH      = 64;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                Start;
  logic                ByteValid;
  logic [7:0]          ByteData;
  logic                ByteReady;
  logic                WriteEnable;
  logic [31:0]         WriteAddress;
  logic [31:0]         WriteData;
  logic                Busy;
  logic                CpuHold;
  logic                Done;
  logic                Error;
  logic [ADDR_WIDTH:0] WordsWritten;

  instruction_loader #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .Start        (Start),
    .ByteValid    (ByteValid),
    .ByteData     (ByteData),
    .ByteReady    (ByteReady),
    .WriteEnable  (WriteEnable),
    .WriteAddress (WriteAddress),
    .WriteData    (WriteData),
    .Busy         (Busy),
    .CpuHold      (CpuHold),
    .Done         (Done),
    .Error        (Error),
    .WordsWritten (WordsWritten)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   wr_count = 0;
  bit   rand_gaps = 1'b0;
  logic start_with_byte = 1'b0;

  // Write monitor: samples mid-cycle, pops the scoreboard on every strobe.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (!reset_n) begin
      checks++;
      if (WriteEnable !== 1'b0) begin
        failures++;
        $display("FAIL we_in_reset got=%b want=0", WriteEnable);
      end
    end else if (WriteEnable === 1'b1) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%h data=%h want=no write", WriteAddress, WriteData);
      end else begin
        e = exp_q.pop_front();
        if (WriteAddress !== e.addr) begin
          failures++;
          $display("FAIL write_addr got=%h want=%h", WriteAddress, e.addr);
        end
        checks++;
        if (WriteData !== e.data) begin
          failures++;
          $display("FAIL write_data addr=%h got=%h want=%h", e.addr, WriteData, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic rdy;
    if (rand_gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    ByteValid = 1'b1;
    ByteData  = b;
    Start     = start_with_byte;
    n   = 0;
    rdy = 1'b0;
    do begin
      @(negedge clk);
      rdy = (ByteReady === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 64);
    ByteValid = 1'b0;
    Start     = 1'b0;
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL byte_accept_timeout byte=%h got=no ByteReady want=accept within 64 cycles", b);
    end
  endtask

  task automatic send_header(input logic [15:0] n);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] w);
    exp_q.push_back('{addr, w});
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (Busy !== 1'b0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_timeout got Busy=%b want=0 within 200 cycles", tag, Busy);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    Start     = 1'b0;
    ByteValid = 1'b0;
    ByteData  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ByteReady, WriteEnable, Busy, CpuHold, Done, Error} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=000000",
               {ByteReady, WriteEnable, Busy, CpuHold, Done, Error});
    end
    checks++;
    if ({WriteAddress, WriteData} !== 64'h0) begin
      failures++;
      $display("FAIL reset_write_bus got=%h/%h want=0/0", WriteAddress, WriteData);
    end
    checks++;
    if (WordsWritten !== '0) begin
      failures++;
      $display("FAIL reset_words got=%0d want=0", WordsWritten);
    end
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ByteReady, Busy, Done} !== 3'b0) begin
      failures++;
      $display("FAIL idle_after_reset got=%b want=000", {ByteReady, Busy, Done});
    end
  endtask

  task automatic test_basic();
    pulse_start();
    checks++;
    if ({Busy, CpuHold, ByteReady} !== 3'b111) begin
      failures++;
      $display("FAIL start_latency got=%b want=111", {Busy, CpuHold, ByteReady});
    end
    send_header(16'h0002);
    send_word(32'd0, 32'h00001825);
    send_word(32'd1, 32'h24020001);
    checks++;
    if (WriteEnable !== 1'b1 || Done !== 1'b0) begin
      failures++;
      $display("FAIL basic_last_write got we=%b done=%b want we=1 done=0", WriteEnable, Done);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({Done, Busy, Error, WriteEnable} !== 4'b1000) begin
      failures++;
      $display("FAIL basic_done_flags got=%b want=1000", {Done, Busy, Error, WriteEnable});
    end
    checks++;
    if (WordsWritten !== 7'd2) begin
      failures++;
      $display("FAIL basic_words got=%0d want=2", WordsWritten);
    end
    checks++;
    if (WriteData !== 32'h24020001 || WriteAddress !== 32'd1) begin
      failures++;
      $display("FAIL basic_hold got=%h@%h want=24020001@00000001", WriteData, WriteAddress);
    end
  endtask

  task automatic test_zero_header();
    int w0 = wr_count;
    pulse_start();
    checks++;
    if (Done !== 1'b0 || WordsWritten !== '0) begin
      failures++;
      $display("FAIL zero_start_clear got done=%b words=%0d want done=0 words=0", Done, WordsWritten);
    end
    send_header(16'h0000);
    @(posedge clk);
    #1;
    checks++;
    if ({Done, Error, Busy} !== 3'b100) begin
      failures++;
      $display("FAIL zero_flags got=%b want=100", {Done, Error, Busy});
    end
    checks++;
    if (wr_count != w0) begin
      failures++;
      $display("FAIL zero_writes got=%0d want=0", wr_count - w0);
    end
  endtask

  task automatic test_oversize();
    int w0 = wr_count;
    pulse_start();
    send_header(16'h0041);
    checks++;
    if ({Error, Done, Busy} !== 3'b110) begin
      failures++;
      $display("FAIL oversize_flags got=%b want=110", {Error, Done, Busy});
    end
    ByteValid = 1'b1;
    ByteData  = 8'hAA;
    @(negedge clk);
    checks++;
    if (ByteReady !== 1'b0) begin
      failures++;
      $display("FAIL oversize_ready got=%b want=0", ByteReady);
    end
    @(posedge clk);
    #1;
    ByteValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wr_count != w0 || WordsWritten !== '0) begin
      failures++;
      $display("FAIL oversize_writes got=%0d words=%0d want=0 words=0", wr_count - w0, WordsWritten);
    end
  endtask

  task automatic test_full_depth();
    int w0 = wr_count;
    pulse_start();
    rand_gaps = 1'b1;
    send_header(16'(DEPTH));
    for (int i = 0; i < DEPTH; i++) send_word(32'(i), $urandom);
    rand_gaps = 1'b0;
    wait_idle("full");
    checks++;
    if (WordsWritten !== 7'd64 || wr_count - w0 != DEPTH) begin
      failures++;
      $display("FAIL full_count got words=%0d writes=%0d want=64/64", WordsWritten, wr_count - w0);
    end
    checks++;
    if ({Done, Error, Busy, CpuHold} !== 4'b1000) begin
      failures++;
      $display("FAIL full_flags got=%b want=1000", {Done, Error, Busy, CpuHold});
    end
    checks++;
    if (WriteAddress !== 32'd63) begin
      failures++;
      $display("FAIL full_last_addr got=%0d want=63", WriteAddress);
    end
  endtask

  task automatic test_start_during_data();
    pulse_start();
    send_header(16'h0002);
    send_word(32'd0, 32'h8C010004);
    @(posedge clk);
    #1;
    pulse_start();
    checks++;
    if (Busy !== 1'b1 || WordsWritten !== 7'd1 || ByteReady !== 1'b1) begin
      failures++;
      $display("FAIL start_ignored got busy=%b words=%0d ready=%b want 1/1/1",
               Busy, WordsWritten, ByteReady);
    end
    exp_q.push_back('{32'd1, 32'hAC220008});
    start_with_byte = 1'b1;
    send_byte(8'hAC);
    start_with_byte = 1'b0;
    send_byte(8'h22);
    send_byte(8'h00);
    send_byte(8'h08);
    @(posedge clk);
    #1;
    checks++;
    if ({Done, Error, Busy} !== 3'b100 || WordsWritten !== 7'd2) begin
      failures++;
      $display("FAIL start_during_data_end got flags=%b words=%0d want 100/2",
               {Done, Error, Busy}, WordsWritten);
    end
  endtask

  task automatic test_reset_midload();
    pulse_start();
    send_header(16'h0003);
    send_word(32'd0, 32'hDEADBEEF);
    send_byte(8'h11);
    send_byte(8'h22);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ByteReady, WriteEnable, Busy, CpuHold, Done, Error} !== 6'b0) begin
      failures++;
      $display("FAIL midreset_flags got=%b want=000000",
               {ByteReady, WriteEnable, Busy, CpuHold, Done, Error});
    end
    checks++;
    if ({WriteAddress, WriteData} !== 64'h0 || WordsWritten !== '0) begin
      failures++;
      $display("FAIL midreset_bus got=%h/%h words=%0d want=0/0/0", WriteAddress, WriteData, WordsWritten);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL midreset_pending got=%0d want=0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    pulse_start();
    send_header(16'h0001);
    send_word(32'd0, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    checks++;
    if (Done !== 1'b1 || WordsWritten !== 7'd1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL restart_load got done=%b words=%0d busy=%b want 1/1/0", Done, WordsWritten, Busy);
    end
  endtask

  initial begin : main
    test_reset();
    test_basic();
    test_zero_header();
    test_oversize();
    test_full_depth();
    test_start_during_data();
    test_reset_midload();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
